// File: rtl/microwave_timer_ctrl.sv
// ---------------------------------------------------------------------------
// microwave_timer_ctrl
//
// Microwave oven controller. It runs a countdown cook timer in ticks of
// TICK_DIV clock cycles, drives the magnetron with a power-level duty cycle,
// rings a bell of bounded length when cooking ends, and supports pausing and
// resuming when the door is opened mid-cook.
//
// States: CLOSED (idle, door shut), COOK, PAUSE (door opened mid-cook),
//         BELL (cook finished), OPEN (door open, no cook pending).
//
// Ports:
//   clk        in   1       clock, rising edge
//   nrst       in   1       asynchronous active-low reset
//   door       in   1       1 = door open
//   start      in   1       start/resume key (level)
//   cancel     in   1       cancel key (level)
//   time_in    in   TIME_W  cook time in ticks, taken on start in CLOSED
//   power      in   PWR_W   heat-on cycles per PWM period, taken with time_in
//   heat       out  1       magnetron enable
//   light      out  1       lamp
//   bell       out  1       buzzer
//   remaining  out  TIME_W  ticks left
//
// All outputs come from flops. They are decoded from the next state and the
// next counter values, so each output matches the registered state it sits
// beside, and no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module microwave_timer_ctrl #(
  parameter int TIME_W      = 8,
  parameter int TICK_DIV    = 4,
  parameter int PWM_PERIOD  = 4,
  parameter int PWR_W       = $clog2(PWM_PERIOD + 1),
  parameter int BELL_CYCLES = 3,
  parameter int AUTO_RESUME = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              door,
  input  logic              start,
  input  logic              cancel,
  input  logic [TIME_W-1:0] time_in,
  input  logic [PWR_W-1:0]  power,
  output logic              heat,
  output logic              light,
  output logic              bell,
  output logic [TIME_W-1:0] remaining
);

  // Counter widths are kept at least 1 bit wide, so TICK_DIV=1 or
  // BELL_CYCLES<=1 still elaborate.
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BELL_W = (BELL_CYCLES > 1) ? $clog2(BELL_CYCLES) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_ONE   = PRE_W'(1);
  localparam logic [PWR_W-1:0]  PWM_LAST  = PWR_W'(PWM_PERIOD - 1);
  localparam logic [PWR_W-1:0]  PWM_ONE   = PWR_W'(1);
  localparam logic [BELL_W-1:0] BELL_LAST = BELL_W'((BELL_CYCLES > 0) ? BELL_CYCLES - 1 : 0);
  localparam logic [BELL_W-1:0] BELL_ONE  = BELL_W'(1);
  localparam logic [TIME_W-1:0] REM_ONE   = TIME_W'(1);

  typedef enum logic [2:0] {
    ST_CLOSED = 3'd0,
    ST_COOK   = 3'd1,
    ST_PAUSE  = 3'd2,
    ST_BELL   = 3'd3,
    ST_OPEN   = 3'd4
  } state_t;

  state_t              state_q,    state_d;
  logic [TIME_W-1:0]   rem_q,      rem_d;
  logic [PRE_W-1:0]    pre_cnt_q,  pre_cnt_d;
  logic [PWR_W-1:0]    pwm_cnt_q,  pwm_cnt_d;
  logic [BELL_W-1:0]   bell_cnt_q, bell_cnt_d;
  logic [PWR_W-1:0]    power_q,    power_d;
  logic                heat_q,     heat_d;
  logic                light_q,    light_d;
  logic                bell_q,     bell_d;
  logic                tick_s;

  // State, counter and output registers with asynchronous reset
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_CLOSED;
      rem_q      <= '0;
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      bell_cnt_q <= '0;
      power_q    <= '0;
      heat_q     <= 1'b0;
      light_q    <= 1'b0;
      bell_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      bell_cnt_q <= bell_cnt_d;
      power_q    <= power_d;
      heat_q     <= heat_d;
      light_q    <= light_d;
      bell_q     <= bell_d;
    end
  end

  assign tick_s = (pre_cnt_q == PRE_LAST);

  // Next-state and counter update logic
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    pre_cnt_d  = pre_cnt_q;
    pwm_cnt_d  = pwm_cnt_q;
    bell_cnt_d = bell_cnt_q;
    power_d    = power_q;

    case (state_q)
      ST_CLOSED: begin
        if (door) begin
          state_d = ST_OPEN;
        end else if (start && (time_in != '0)) begin
          // A zero cook time is treated as no request at all.
          state_d   = ST_COOK;
          rem_d     = time_in;
          power_d   = power;
          pre_cnt_d = '0;
          pwm_cnt_d = '0;
        end else begin
          state_d = ST_CLOSED;
        end
      end

      ST_COOK: begin
        if (door) begin
          // Every counter freezes, so a resume continues mid-tick and mid-period.
          state_d = ST_PAUSE;
        end else if (cancel) begin
          state_d = ST_CLOSED;
          rem_d   = '0;
        end else begin
          pre_cnt_d = tick_s ? '0 : (pre_cnt_q + PRE_ONE);
          pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : (pwm_cnt_q + PWM_ONE);
          if (tick_s) begin
            if (rem_q == REM_ONE) begin
              state_d    = ST_BELL;
              rem_d      = '0;
              bell_cnt_d = '0;
            end else begin
              rem_d = rem_q - REM_ONE;
            end
          end else begin
            rem_d = rem_q;
          end
        end
      end

      ST_PAUSE: begin
        if (door) begin
          if (cancel) begin
            state_d = ST_OPEN;
            rem_d   = '0;
          end else begin
            state_d = ST_PAUSE;
          end
        end else if ((AUTO_RESUME != 0) || start) begin
          state_d = ST_COOK;
        end else if (cancel) begin
          state_d = ST_CLOSED;
          rem_d   = '0;
        end else begin
          state_d = ST_PAUSE;
        end
      end

      ST_BELL: begin
        if (door) begin
          state_d = ST_OPEN;
        end else if (cancel) begin
          state_d = ST_CLOSED;
        end else if ((BELL_CYCLES != 0) && (bell_cnt_q == BELL_LAST)) begin
          state_d = ST_CLOSED;
        end else begin
          // With BELL_CYCLES == 0 the count just wraps and the bell keeps ringing.
          bell_cnt_d = bell_cnt_q + BELL_ONE;
        end
      end

      ST_OPEN: begin
        if (!door) begin
          state_d = ST_CLOSED;
        end else begin
          state_d = ST_OPEN;
        end
      end

      default: begin
        state_d = ST_CLOSED;
        rem_d   = '0;
      end
    endcase
  end

  // Output decode from the next registered state and counters
  always_comb begin
    heat_d  = 1'b0;
    light_d = 1'b0;
    bell_d  = 1'b0;
    case (state_d)
      ST_COOK: begin
        heat_d  = (pwm_cnt_d < power_d);
        light_d = 1'b1;
      end
      ST_PAUSE: begin
        light_d = 1'b1;
      end
      ST_OPEN: begin
        light_d = 1'b1;
      end
      ST_BELL: begin
        bell_d = 1'b1;
      end
      default: begin
        heat_d  = 1'b0;
        light_d = 1'b0;
        bell_d  = 1'b0;
      end
    endcase
  end

  assign heat      = heat_q;
  assign light     = light_q;
  assign bell      = bell_q;
  assign remaining = rem_q;

endmodule
